calendar_counter: RTL and testbench



---
 rtl/calendar_pkg.sv | 41 ++++
 rtl/calendar_bcd2_counter.sv | 46 ++++
 rtl/calendar_counter.sv | 99 +++++++++
 tb/tb_calendar_counter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar constants and helpers, reused by the time-setting stage.
// CALENDAR_LEAP_YEAR_EN selects 29-day Februaries in leap years.
package calendar_pkg;

  localparam logic [7:0]  SEC_MAX   = 8'h59;
  localparam logic [7:0]  MIN_MAX   = 8'h59;
  localparam logic [7:0]  HOUR_MAX  = 8'h23;
  localparam logic [7:0]  MONTH_MAX = 8'h12;
  localparam logic [7:0]  YEAR_MAX2 = 8'h99;
  localparam logic [3:0]  WEEK_MAX  = 4'd6;

  localparam logic [15:0] RST_YEAR   = 16'h2023;
  localparam logic [7:0]  RST_MONTH  = 8'h01;
  localparam logic [7:0]  RST_DAY    = 8'h01;
  localparam logic [7:0]  RST_HOUR   = 8'h00;
  localparam logic [7:0]  RST_MINUTE = 8'h00;
  localparam logic [7:0]  RST_SEC    = 8'h00;
  localparam logic [3:0]  RST_WEEK   = 4'd0;

  // Last day of a BCD month; anything outside the 30-day set and February is 31.
  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  // 10*T+U is a multiple of 4 exactly when 2*T+U is.
  function automatic logic bcd_div4(input logic [7:0] v);
    logic [5:0] s;
    s = {1'b0, v[7:4], 1'b0} + {2'b00, v[3:0]};
    return s[1:0] == 2'b00;
  endfunction

  function automatic logic is_leap_year(input logic [15:0] year);
    if (year[7:0] != 8'h00) return bcd_div4(year[7:0]);
    return bcd_div4(year[15:8]);
  endfunction

endpackage

// File: rtl/calendar_bcd2_counter.sv
// Two-digit packed-BCD counter with load, min/max wrap and a combinational carry
// so a whole chain of these resolves in a single clock.
module bcd2_counter
  import calendar_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] min,
  input  logic [7:0] max,
  output logic [7:0] value,
  output logic       carry
);

  logic [3:0] lo_n;
  logic [3:0] hi_n;
  logic       at_max;

  // Digits A..F count as 9, so the compare and the increment never see them.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    lo_n = (value[3:0] > 4'd9) ? 4'd9 : value[3:0];
    hi_n = (value[7:4] > 4'd9) ? 4'd9 : value[7:4];
  end

  assign at_max = {hi_n, lo_n} >= max;
  assign carry  = inc & at_max;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (at_max)              value <= min;
      else if (lo_n == 4'd9)   value <= {hi_n + 4'd1, 4'd0};
      else                     value <= {hi_n, lo_n + 4'd1};
    end
  end

endmodule

// File: rtl/calendar_counter.sv
// Real-time calendar: BCD sec..year chain plus binary weekday, advanced by tick_1hz.
// Define CALENDAR_LEAP_YEAR_EN to give February 29 days in leap years.
module calendar_counter
  import calendar_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        run_en,
  input  logic        load,
  input  logic [15:0] year_in,
  input  logic [7:0]  month_in,
  input  logic [7:0]  day_in,
  input  logic [7:0]  hour_in,
  input  logic [7:0]  minute_in,
  input  logic [7:0]  sec_in,
  input  logic [3:0]  week_in,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic [3:0]  week,
  output logic        day_wrap
);

  logic       sec_inc;
  logic       sec_carry;
  logic       min_carry;
  logic       hour_carry;
  logic       day_carry;
  logic       month_carry;
  logic       year_lo_carry;
  logic       leap;
  logic [7:0] day_max;
  logic [7:0] year_lo;
  logic [7:0] year_hi;

  // A tick coinciding with load is dropped, not deferred.
  assign sec_inc = tick_1hz & run_en & ~load;

`ifdef CALENDAR_LEAP_YEAR_EN
  assign leap = is_leap_year(year);
`else
  assign leap = 1'b0;
`endif

  assign day_max = days_in_month(month, leap);
  assign year    = {year_hi, year_lo};

  bcd2_counter #(.RST_VAL(RST_SEC)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .load(load), .load_val(sec_in),
    .min(8'h00), .max(SEC_MAX), .value(sec), .carry(sec_carry)
  );

  bcd2_counter #(.RST_VAL(RST_MINUTE)) u_minute (
    .clk(clk), .rst(rst), .inc(sec_carry), .load(load), .load_val(minute_in),
    .min(8'h00), .max(MIN_MAX), .value(minute), .carry(min_carry)
  );

  bcd2_counter #(.RST_VAL(RST_HOUR)) u_hour (
    .clk(clk), .rst(rst), .inc(min_carry), .load(load), .load_val(hour_in),
    .min(8'h00), .max(HOUR_MAX), .value(hour), .carry(hour_carry)
  );

  bcd2_counter #(.RST_VAL(RST_DAY)) u_day (
    .clk(clk), .rst(rst), .inc(hour_carry), .load(load), .load_val(day_in),
    .min(8'h01), .max(day_max), .value(day), .carry(day_carry)
  );

  bcd2_counter #(.RST_VAL(RST_MONTH)) u_month (
    .clk(clk), .rst(rst), .inc(day_carry), .load(load), .load_val(month_in),
    .min(8'h01), .max(MONTH_MAX), .value(month), .carry(month_carry)
  );

  bcd2_counter #(.RST_VAL(RST_YEAR[7:0])) u_year_lo (
    .clk(clk), .rst(rst), .inc(month_carry), .load(load), .load_val(year_in[7:0]),
    .min(8'h00), .max(YEAR_MAX2), .value(year_lo), .carry(year_lo_carry)
  );

  // Year 9999 rolls to 0000; the top carry has nowhere to go.
  bcd2_counter #(.RST_VAL(RST_YEAR[15:8])) u_year_hi (
    .clk(clk), .rst(rst), .inc(year_lo_carry), .load(load), .load_val(year_in[15:8]),
    .min(8'h00), .max(YEAR_MAX2), .value(year_hi), .carry()
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      week     <= RST_WEEK;
      day_wrap <= 1'b0;
    end else begin
      day_wrap <= hour_carry;
      if (load)            week <= week_in;
      else if (hour_carry) week <= (week >= WEEK_MAX) ? 4'd0 : week + 4'd1;
    end
  end

endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench for calendar_counter: directed corner cases plus a randomized
// run against an integer calendar model.
module tb_calendar_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        run_en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] year_in = '0;
  logic [7:0]  month_in = '0, day_in = '0, hour_in = '0, minute_in = '0, sec_in = '0;
  logic [3:0]  week_in = '0;
  logic [15:0] year;
  logic [7:0]  month, day, hour, minute, sec;
  logic [3:0]  week;
  logic        day_wrap;

  calendar_counter dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .run_en(run_en), .load(load),
    .year_in(year_in), .month_in(month_in), .day_in(day_in), .hour_in(hour_in),
    .minute_in(minute_in), .sec_in(sec_in), .week_in(week_in),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .sec(sec),
    .week(week), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  wire [60:0] dut_vec = {year, month, day, hour, minute, sec, week, day_wrap};

  // Reference calendar held as plain integers.
  int m_year, m_month, m_day, m_hour, m_min, m_sec, m_week;
  bit m_wrap;

  function automatic int from_bcd(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd4(input int n);
    logic [15:0] r;
    int x = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd2(input int n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int month_len(input int y, input int m);
    int len = 31;
    if (m == 4 || m == 6 || m == 9 || m == 11) len = 30;
    else if (m == 2) begin
      len = 28;
`ifdef CALENDAR_LEAP_YEAR_EN
      if ((y % 4 == 0 && y % 100 != 0) || (y % 400 == 0)) len = 29;
`endif
    end
    return len;
  endfunction

  function automatic logic [60:0] model_vec();
    return {bcd4(m_year), bcd2(m_month), bcd2(m_day), bcd2(m_hour), bcd2(m_min),
            bcd2(m_sec), 4'(m_week), m_wrap};
  endfunction

  task automatic model_advance();
    if (m_sec >= 59) begin
      m_sec = 0;
      if (m_min >= 59) begin
        m_min = 0;
        if (m_hour >= 23) begin
          m_hour = 0;
          m_wrap = 1'b1;
          m_week = (m_week >= 6) ? 0 : m_week + 1;
          if (m_day >= month_len(m_year, m_month)) begin
            m_day = 1;
            if (m_month >= 12) begin
              m_month = 1;
              m_year = (m_year >= 9999) ? 0 : m_year + 1;
            end else m_month++;
          end else m_day++;
        end else m_hour++;
      end else m_min++;
    end else m_sec++;
  endtask

  task automatic set_in(input int y, input int mo, input int d, input int h,
                        input int mi, input int s, input int w);
    year_in = bcd4(y); month_in = bcd2(mo); day_in = bcd2(d);
    hour_in = bcd2(h); minute_in = bcd2(mi); sec_in = bcd2(s); week_in = 4'(w);
  endtask

  // One clock: drive inputs, let the edge happen, update the model, settle for sampling.
  task automatic cycle(input bit r, input bit t, input bit en, input bit ld);
    rst = r; tick_1hz = t; run_en = en; load = ld;
    @(posedge clk);
    m_wrap = 1'b0;
    if (r) begin
      m_year = 2023; m_month = 1; m_day = 1; m_hour = 0; m_min = 0; m_sec = 0; m_week = 0;
    end else if (ld) begin
      m_year = from_bcd(year_in); m_month = from_bcd({8'h00, month_in});
      m_day = from_bcd({8'h00, day_in}); m_hour = from_bcd({8'h00, hour_in});
      m_min = from_bcd({8'h00, minute_in}); m_sec = from_bcd({8'h00, sec_in});
      m_week = int'(week_in);
    end else if (t && en) begin
      model_advance();
    end
    #1;
    rst = 1'b0; tick_1hz = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    logic [60:0] exp = {16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0};
    cycle(1, 0, 0, 0);
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL reset got=%h exp=%h", dut_vec, exp);
    end
    set_in(1999, 7, 7, 7, 7, 7, 3);
    cycle(1, 1, 1, 1);
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL reset_over_load got=%h exp=%h", dut_vec, exp);
    end
  endtask

  task automatic test_year_rollover();
    logic [60:0] exp;
    set_in(2023, 12, 31, 23, 59, 59, 6);
    cycle(0, 0, 1, 1);
    exp = {16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd6, 1'b0};
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL load_value got=%h exp=%h", dut_vec, exp);
    end
    cycle(0, 1, 1, 0);
    exp = {16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1};
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL year_rollover got=%h exp=%h", dut_vec, exp);
    end
    cycle(0, 0, 1, 0);
    exp[0] = 1'b0;
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL day_wrap_one_cycle got=%h exp=%h", dut_vec, exp);
    end
  endtask

  task automatic test_leap();
    int yrs[3] = '{2024, 2100, 2000};
    logic [15:0] exp_md[3];
`ifdef CALENDAR_LEAP_YEAR_EN
    exp_md = '{16'h0229, 16'h0301, 16'h0229};
`else
    exp_md = '{16'h0301, 16'h0301, 16'h0301};
`endif
    for (int i = 0; i < 3; i++) begin
      logic [60:0] exp;
      set_in(yrs[i], 2, 28, 23, 59, 59, 0);
      cycle(0, 0, 1, 1);
      cycle(0, 1, 1, 0);
      exp = {bcd4(yrs[i]), exp_md[i], 8'h00, 8'h00, 8'h00, 4'd1, 1'b1};
      checks++;
      if (dut_vec !== exp) begin
        failures++; $display("FAIL feb_end_%0d got=%h exp=%h", yrs[i], dut_vec, exp);
      end
    end
  endtask

  task automatic test_load_priority();
    set_in(2023, 6, 15, 12, 34, 56, 4);
    cycle(0, 1, 1, 1);
    checks++;
    if ({hour, minute, sec} !== 24'h123456) begin
      failures++; $display("FAIL load_over_tick got=%h exp=%h", {hour, minute, sec}, 24'h123456);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (sec !== 8'h56) begin
      failures++; $display("FAIL tick_not_deferred got=%h exp=%h", sec, 8'h56);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL load_over_tick_full got=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_hold();
    logic [60:0] held;
    set_in(2023, 3, 10, 8, 15, 20, 2);
    cycle(0, 0, 1, 1);
    held = {16'h2023, 8'h03, 8'h10, 8'h08, 8'h15, 8'h20, 4'd2, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 0);
      checks++;
      if (dut_vec !== held) begin
        failures++; $display("FAIL hold_tick%0d got=%h exp=%h", i, dut_vec, held);
      end
    end
    cycle(0, 1, 1, 0);
    checks++;
    if (sec !== 8'h21) begin
      failures++; $display("FAIL resume_tick got=%h exp=%h", sec, 8'h21);
    end
    set_in(2030, 9, 9, 9, 9, 9, 5);
    cycle(0, 1, 0, 1);
    held = {16'h2030, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 4'd5, 1'b0};
    checks++;
    if (dut_vec !== held) begin
      failures++; $display("FAIL load_while_held got=%h exp=%h", dut_vec, held);
    end
  endtask

  task automatic test_overrange();
    logic [60:0] exp;
    set_in(2023, 4, 35, 23, 59, 59, 2);
    cycle(0, 0, 1, 1);
    cycle(0, 1, 1, 0);
    exp = {16'h2023, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 4'd3, 1'b1};
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL day_overrange got=%h exp=%h", dut_vec, exp);
    end
    set_in(9999, 12, 31, 27, 59, 59, 9);
    cycle(0, 0, 1, 1);
    cycle(0, 1, 1, 0);
    exp = {16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0, 1'b1};
    checks++;
    if (dut_vec !== exp) begin
      failures++; $display("FAIL hour_week_overrange got=%h exp=%h", dut_vec, exp);
    end
  endtask

  task automatic test_random();
    int yr_pick[6] = '{1999, 2000, 2023, 2024, 2100, 9999};
    for (int n = 0; n < 4000; n++) begin
      bit r  = ($urandom_range(999) == 0);
      bit ld = ($urandom_range(99) < 4);
      bit t  = ($urandom_range(99) < 70);
      bit en = ($urandom_range(99) < 90);
      if (ld) begin
        int y = ($urandom_range(3) == 0) ? int'($urandom_range(9999))
                                         : yr_pick[$urandom_range(5)];
        int mo = int'($urandom_range(1, 12));
        set_in(y, mo, int'($urandom_range(1, 31)), int'($urandom_range(20, 23)),
               int'($urandom_range(57, 59)), int'($urandom_range(50, 59)),
               int'($urandom_range(0, 9)));
      end
      cycle(r, t, en, ld);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        if (failures < 20) $display("FAIL random_cycle%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_year_rollover();
    test_leap();
    test_load_priority();
    test_hold();
    test_overrange();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
